// File: rtl/cpu_phase_pkg.sv
// Shared definitions for the multicycle core: phase codes from the
// sequencer, datapath width, and the default halt encoding.
package cpu_phase_pkg;

    localparam int unsigned XLEN = 16;

    typedef enum logic [1:0] {
        PH_ILLEGAL = 2'b00,
        PH_FETCH   = 2'b01,
        PH_DECODE  = 2'b10,
        PH_EXEC    = 2'b11
    } phase_e;

    localparam logic [XLEN-1:0] HALT_WORD_DEFAULT = 16'hFFFF;

    // Instructions are halfword aligned; clear bit 0 of any redirect target.
    function automatic logic [XLEN-1:0] align_hw(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(1);
    endfunction

endpackage

// File: rtl/fetch_stage_pc_next_calc.sv
// Next-PC selection: hold on halt, redirect on taken branch, else step.
module pc_next_calc
    import cpu_phase_pkg::*;
#(
    parameter int unsigned PC_STEP = 2
) (
    input  logic [XLEN-1:0] pc,
    input  logic            hold,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] next_pc
);

    // Priority: halt hold beats branch, branch beats sequential step.
    always_comb begin
        next_pc = pc + XLEN'(PC_STEP);
        if (hold) begin
            next_pc = pc;
        end else if (branch_taken) begin
            next_pc = align_hw(branch_target);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch / PC unit driven by the 3-phase sequencer.
module fetch_stage
    import cpu_phase_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int unsigned PC_STEP   = 2,
    parameter logic [15:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  phase,
    input  logic [15:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    output logic [15:0] ir,
    output logic        ir_valid,
    output logic [15:0] pc,
    output logic        retire,
    output logic [15:0] instr_count,
    output logic        halted,
    output logic        phase_err
);

    phase_e          ph;
    logic            fetch_pending;
    logic            is_halt;
    logic [XLEN-1:0] next_pc;

    assign ph        = phase_e'(phase);
    assign is_halt   = (ir == HALT_WORD);
    assign imem_addr = pc;
    assign imem_req  = (ph == PH_FETCH) && !halted && !rst;

    pc_next_calc #(
        .PC_STEP(PC_STEP)
    ) u_pc_next (
        .pc            (pc),
        .hold          (is_halt),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .next_pc       (next_pc)
    );

    // Per-phase state update; retire defaults low so it pulses for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc            <= RESET_PC;
            ir            <= '0;
            ir_valid      <= 1'b0;
            fetch_pending <= 1'b0;
            retire        <= 1'b0;
            instr_count   <= '0;
            halted        <= 1'b0;
            phase_err     <= 1'b0;
        end else begin
            retire <= 1'b0;
            case (ph)
                PH_FETCH: begin
                    if (!halted) begin
                        fetch_pending <= 1'b1;
                    end
                end
                PH_DECODE: begin
                    if (fetch_pending) begin
                        ir            <= imem_rdata;
                        ir_valid      <= 1'b1;
                        fetch_pending <= 1'b0;
                    end else if (!halted) begin
                        phase_err <= 1'b1;
                    end
                end
                PH_EXEC: begin
                    if (ir_valid) begin
                        pc          <= next_pc;
                        halted      <= halted | is_halt;
                        ir_valid    <= 1'b0;
                        retire      <= 1'b1;
                        instr_count <= instr_count + 16'd1;
                    end else if (!halted) begin
                        phase_err <= 1'b1;
                    end
                end
                default: begin
                    phase_err <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector tables, corner sequences and a
// randomized run checked against a rule-level reference model.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic [1:0]  phase;
    logic        branch_taken;
    logic [15:0] branch_target;

    logic [15:0] imem_rdata, imem_addr, ir, pc, instr_count;
    logic        imem_req, ir_valid, retire, halted, phase_err;

    logic [15:0] w_rdata, w_addr, w_ir, w_pc, w_count;
    logic        w_req, w_irv, w_retire, w_halted, w_err;

    logic [15:0] mem [256];

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .clk(clk), .rst(rst), .phase(phase), .imem_rdata(imem_rdata),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .ir(ir), .ir_valid(ir_valid),
        .pc(pc), .retire(retire), .instr_count(instr_count), .halted(halted),
        .phase_err(phase_err)
    );

    fetch_stage #(.RESET_PC(16'hFFFE)) dut_w (
        .clk(clk), .rst(rst), .phase(phase), .imem_rdata(w_rdata),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(w_req), .imem_addr(w_addr), .ir(w_ir), .ir_valid(w_irv),
        .pc(w_pc), .retire(w_retire), .instr_count(w_count), .halted(w_halted),
        .phase_err(w_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory, halfword indexed.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= mem[imem_addr[8:1]];
        if (w_req)    w_rdata    <= mem[w_addr[8:1]];
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  ph;
        logic        bt;
        logic [15:0] tgt;
        logic        req;
        logic [15:0] addr;
        logic [15:0] pc;
        logic [15:0] ir;
        logic        irv;
        logic        ret;
        logic [15:0] cnt;
        logic        hlt;
    } vec_t;

    vec_t tbl_a [9];
    vec_t tbl_b [6];

    // Starts and ends at a falling edge.
    task automatic apply(input vec_t v, input string tag);
        phase = v.ph; branch_taken = v.bt; branch_target = v.tgt;
        #1;
        chk({tag, "_req"}, 16'(imem_req), 16'(v.req));
        if (v.req) chk({tag, "_addr"}, imem_addr, v.addr);
        @(posedge clk); #1;
        chk({tag, "_pc"},  pc, v.pc);
        chk({tag, "_ir"},  ir, v.ir);
        chk({tag, "_irv"}, 16'(ir_valid), 16'(v.irv));
        chk({tag, "_ret"}, 16'(retire), 16'(v.ret));
        chk({tag, "_cnt"}, instr_count, v.cnt);
        chk({tag, "_hlt"}, 16'(halted), 16'(v.hlt));
        chk({tag, "_err"}, 16'(phase_err), 16'h0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; phase = 2'b01; branch_taken = 1'b0; branch_target = '0;
        #1;
        chk("rst_req", 16'(imem_req), 16'h0);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_ir", ir, 16'h0000);
        chk("rst_irv", 16'(ir_valid), 16'h0);
        chk("rst_ret", 16'(retire), 16'h0);
        chk("rst_cnt", instr_count, 16'h0000);
        chk("rst_hlt", 16'(halted), 16'h0);
        chk("rst_err", 16'(phase_err), 16'h0);
        chk("rst_pc_w", w_pc, 16'hFFFE);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference model state, advanced one clock at a time from the rules.
    logic [15:0] m_pc, m_ir, m_cnt, m_rdata;
    logic        m_irv, m_pend, m_ret, m_halt, m_err;

    task automatic model_reset();
        m_pc = 16'h0000; m_ir = '0; m_cnt = '0;
        m_irv = 0; m_pend = 0; m_ret = 0; m_halt = 0; m_err = 0;
    endtask

    task automatic model_step(input logic [1:0] p, input logic bt, input logic [15:0] tgt);
        logic [15:0] fetched;
        logic        req;
        req = (p == 2'b01) && !m_halt;
        fetched = mem[m_pc[8:1]];
        m_ret = 0;
        if (p == 2'b00) m_err = 1;
        else if (p == 2'b01) begin
            if (!m_halt) m_pend = 1;
        end else if (p == 2'b10) begin
            if (m_pend) begin m_ir = m_rdata; m_irv = 1; m_pend = 0; end
            else if (!m_halt) m_err = 1;
        end else begin
            if (m_irv) begin
                if (m_ir == 16'hFFFF) m_halt = 1;
                else if (bt) m_pc = {tgt[15:1], 1'b0};
                else m_pc = m_pc + 16'd2;
                m_irv = 0; m_ret = 1; m_cnt = m_cnt + 16'd1;
            end else if (!m_halt) m_err = 1;
        end
        if (req) m_rdata = fetched;
    endtask

    task automatic cmp_model();
        chk("rnd_pc", pc, m_pc);
        chk("rnd_ir", ir, m_ir);
        chk("rnd_irv", 16'(ir_valid), 16'(m_irv));
        chk("rnd_ret", 16'(retire), 16'(m_ret));
        chk("rnd_cnt", instr_count, m_cnt);
        chk("rnd_hlt", 16'(halted), 16'(m_halt));
        chk("rnd_err", 16'(phase_err), 16'(m_err));
    endtask

    initial begin
        rst = 1'b1; phase = 2'b01; branch_taken = 1'b0; branch_target = '0;
        for (int unsigned i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'hFFFF;
        mem[8'h20] = 16'h3333; mem[255] = 16'h1234;

        //        ph    bt tgt        req addr      pc        ir        irv ret cnt      hlt
        tbl_a[0] = '{2'b01, 0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0, 0};
        tbl_a[1] = '{2'b10, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h1111, 1, 0, 16'd0, 0};
        tbl_a[2] = '{2'b11, 0, 16'h0000, 0, 16'h0000, 16'h0002, 16'h1111, 0, 1, 16'd1, 0};
        tbl_a[3] = '{2'b01, 0, 16'h0000, 1, 16'h0002, 16'h0002, 16'h1111, 0, 0, 16'd1, 0};
        tbl_a[4] = '{2'b10, 0, 16'h0000, 0, 16'h0000, 16'h0002, 16'h2222, 1, 0, 16'd1, 0};
        tbl_a[5] = '{2'b11, 0, 16'h0000, 0, 16'h0000, 16'h0004, 16'h2222, 0, 1, 16'd2, 0};
        tbl_a[6] = '{2'b01, 0, 16'h0000, 1, 16'h0004, 16'h0004, 16'h2222, 0, 0, 16'd2, 0};
        tbl_a[7] = '{2'b10, 0, 16'h0000, 0, 16'h0000, 16'h0004, 16'hFFFF, 1, 0, 16'd2, 0};
        tbl_a[8] = '{2'b11, 1, 16'h0100, 0, 16'h0000, 16'h0004, 16'hFFFF, 0, 1, 16'd3, 1};

        tbl_b[0] = '{2'b01, 1, 16'h0041, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0, 0};
        tbl_b[1] = '{2'b10, 1, 16'h0099, 0, 16'h0000, 16'h0000, 16'h1111, 1, 0, 16'd0, 0};
        tbl_b[2] = '{2'b11, 1, 16'h0041, 0, 16'h0000, 16'h0040, 16'h1111, 0, 1, 16'd1, 0};
        tbl_b[3] = '{2'b01, 0, 16'h0000, 1, 16'h0040, 16'h0040, 16'h1111, 0, 0, 16'd1, 0};
        tbl_b[4] = '{2'b10, 0, 16'h0000, 0, 16'h0000, 16'h0040, 16'h3333, 1, 0, 16'd1, 0};
        tbl_b[5] = '{2'b11, 0, 16'h0000, 0, 16'h0000, 16'h0042, 16'h3333, 0, 1, 16'd2, 0};

        @(negedge clk);

        // Sequential run through the halt word, with the wrap DUT in lockstep.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            apply(tbl_a[i], $sformatf("seq%0d", i));
            if (i == 2) chk("wrap_pc", w_pc, 16'h0000);
        end
        for (int i = 0; i < 18; i++) begin
            phase = 2'(i % 3 + 1);
            #1 chk("halt_req", 16'(imem_req), 16'h0);
            @(posedge clk); #1;
            chk("halt_ret", 16'(retire), 16'h0);
            chk("halt_pc", pc, 16'h0004);
            @(negedge clk);
        end
        chk("halt_cnt", instr_count, 16'd3);
        chk("halt_flag", 16'(halted), 16'h1);
        chk("halt_noerr", 16'(phase_err), 16'h0);

        // Branch redirect with bit 0 cleared; branch inputs ignored elsewhere.
        do_reset();
        for (int i = 0; i < 6; i++) apply(tbl_b[i], $sformatf("br%0d", i));

        // Illegal phase code.
        do_reset();
        for (int i = 0; i < 3; i++) apply(tbl_a[i], "pre00");
        phase = 2'b00;
        @(posedge clk); #1;
        chk("ph00_err", 16'(phase_err), 16'h1);
        chk("ph00_pc", pc, 16'h0002);
        chk("ph00_cnt", instr_count, 16'd1);
        @(negedge clk);

        // EXECUTE with nothing loaded.
        do_reset();
        phase = 2'b11;
        @(posedge clk); #1;
        chk("exnv_err", 16'(phase_err), 16'h1);
        chk("exnv_ret", 16'(retire), 16'h0);
        chk("exnv_cnt", instr_count, 16'd0);
        chk("exnv_pc", pc, 16'h0000);
        @(negedge clk);

        // Reset during DECODE of the second instruction.
        do_reset();
        for (int i = 0; i < 4; i++) apply(tbl_a[i], "premid");
        phase = 2'b10;
        #2 rst = 1'b1;
        #1;
        chk("mid_pc", pc, 16'h0000);
        chk("mid_irv", 16'(ir_valid), 16'h0);
        chk("mid_cnt", instr_count, 16'd0);
        chk("mid_ir", ir, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        apply(tbl_a[0], "restart");

        // Randomized run against the reference model.
        for (int unsigned i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 39) == 0) ? 16'hFFFF : 16'($urandom);
        do_reset();
        model_reset();
        begin
            logic [1:0]  p;
            logic        bt;
            logic [15:0] tgt;
            int          seq = 0;
            for (int n = 0; n < 4000; n++) begin
                if ($urandom_range(0, 149) == 0) begin
                    rst = 1'b1;
                    model_reset();
                    #1 cmp_model();
                    @(negedge clk);
                    rst = 1'b0;
                    seq = 0;
                end else begin
                    if ($urandom_range(0, 19) == 0) p = 2'($urandom);
                    else begin p = 2'(seq + 1); seq = (seq + 1) % 3; end
                    bt = 1'($urandom);
                    tgt = 16'($urandom);
                    phase = p; branch_taken = bt; branch_target = tgt;
                    #1;
                    chk("rnd_req", 16'(imem_req), 16'((p == 2'b01) && !m_halt));
                    chk("rnd_addr", imem_addr, m_pc);
                    model_step(p, bt, tgt);
                    @(posedge clk); #1;
                    cmp_model();
                    @(negedge clk);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
